spram_req_ctrl: RTL and testbench

//  Request front-end for the single-port RAM: accepts independent write and read request

---
 rtl/spram_ctrl_pkg.sv | 22 ++
 rtl/spram_rsp_fifo.sv | 68 ++++++
 rtl/spram_req_ctrl.sv | 125 ++++++++++++
 tb/tb_spram_req_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and width helpers for the single-port RAM request controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spram_ctrl_pkg;

    // Which requester owned the RAM port on the most recent granted cycle.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    // Address width for a RAM of the given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width needed to count 0..depth occupied entries inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Response buffer: DEPTH x WIDTH shift-style FIFO whose entry 0 is the visible head.
// Latency: a push is visible at the head on the following cycle when the FIFO was empty.
// Backpressure: caller must not push when full unless popping in the same cycle; such pushes are dropped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   push, push_data        enqueue one word
//   pop                    dequeue the head word (ignored when empty)
//   count                  number of occupied entries
//   head_valid, head_data  current head of the queue
module spram_rsp_fifo
    import spram_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entry [DEPTH];
    logic             pop_eff;
    logic             push_eff;
    logic [CNT_W-1:0] wr_slot;
    logic [IDX_W-1:0] wr_idx;

    assign pop_eff  = pop & head_valid;
    assign push_eff = push & ((count < CNT_W'(DEPTH)) | pop_eff);

    // Entries are kept packed toward index 0, so the next free slot is the
    // occupancy after this cycle's pop has shifted everything down.
    assign wr_slot = count - CNT_W'(pop_eff);
    assign wr_idx  = wr_slot[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
            count <= '0;
        end else begin
            if (pop_eff) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entry[i] <= entry[i+1];
                end
            end
            // Placed after the shift so a simultaneous push lands in the
            // freshly vacated slot.
            if (push_eff) begin
                entry[wr_idx] <= push_data;
            end
            count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = entry[0];

endmodule

// File: rtl/spram_req_ctrl.sv
// Arbitrates independent write/read request streams onto one single-port RAM and buffers read data.
// Latency: grant is combinational in the request cycle; read response is valid 2 cycles after the read handshake.
// Backpressure: rd_ready drops when inflight plus buffered responses would exceed RSP_DEPTH; writes are never blocked by responses.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data   write request stream
//   rd_valid/rd_ready/rd_addr           read request stream
//   rsp_valid/rsp_ready/rsp_data        read response stream
//   ram_w_en/ram_addr/ram_data_in       drive to the RAM's shared port
//   ram_data_out                        registered RAM read data (holds while w_en=1)
module spram_req_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int RSP_DEPTH = 2,
    localparam int ADDR_W   = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_data_in,
    input  logic [WIDTH-1:0]  ram_data_out
);

    localparam int CNT_W = cnt_width(RSP_DEPTH);
    localparam int OCC_W = CNT_W + 1;

    grant_e           last_grant;
    logic             inflight;
    logic [CNT_W-1:0] rsp_count;
    logic             rsp_pop;
    logic [OCC_W-1:0] occupancy;
    logic             rd_ok;
    logic             rd_elig;
    logic             gnt_wr;
    logic             gnt_rd;

    // Credit: every read already granted (inflight or buffered) owns a buffer
    // slot; a pop this cycle frees one immediately so streaming reads with
    // rsp_ready=1 sustain one per cycle.
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign occupancy = OCC_W'(rsp_count) + OCC_W'(inflight) - OCC_W'(rsp_pop);
    assign rd_ok     = occupancy < OCC_W'(RSP_DEPTH);
    assign rd_elig   = rd_valid & rd_ok;

    // One grant per cycle. When both sides are eligible, hand the port to the
    // side that did not have it last. Everything is gated off during reset.
    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (rst_n) begin
            if (wr_valid && rd_elig) begin
                if (last_grant == GNT_WR) begin
                    gnt_rd = 1'b1;
                end else begin
                    gnt_wr = 1'b1;
                end
            end else begin
                gnt_wr = wr_valid;
                gnt_rd = rd_elig;
            end
        end
    end

    assign wr_ready = gnt_wr;
    assign rd_ready = gnt_rd;

    // RAM port drive in the grant cycle; idle cycles present all zeros.
    always_comb begin
        ram_w_en    = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        if (gnt_wr) begin
            ram_w_en    = 1'b1;
            ram_addr    = wr_addr;
            ram_data_in = wr_data;
        end else if (gnt_rd) begin
            ram_addr    = rd_addr;
        end
    end

    // inflight marks the cycle in which ram_data_out carries the previous
    // cycle's read; that word is captured into the buffer at the end of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_RD;
            inflight   <= 1'b0;
        end else begin
            inflight <= gnt_rd;
            if (gnt_wr) begin
                last_grant <= GNT_WR;
            end else if (gnt_rd) begin
                last_grant <= GNT_RD;
            end
        end
    end

    spram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (WIDTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_data  (ram_data_out),
        .pop        (rsp_pop),
        .count      (rsp_count),
        .head_valid (rsp_valid),
        .head_data  (rsp_data)
    );

endmodule

// File: tb/tb_spram_req_ctrl.sv
module tb_spram_req_ctrl;

    localparam int DEPTH     = 8;
    localparam int WIDTH     = 8;
    localparam int RSP_DEPTH = 2;
    localparam int AW        = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             ram_w_en;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_req_ctrl #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .ram_w_en     (ram_w_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Single-port RAM: registered read output that only updates on read cycles.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_w_en) ram[ram_addr] <= ram_data_in;
        else          ram_data_out  <= ram[ram_addr];
    end

    // Reference model: memory contents, queue of expected responses with the
    // cycle at which each becomes visible, and round-robin memory.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               last_was_rd = 1'b1;
    int               cyc = 0;
    logic             e_wr_rdy = 1'b0, e_rd_rdy = 1'b0, e_wen = 1'b0, e_rv = 1'b0;
    logic [AW-1:0]    e_addr = '0;
    logic [WIDTH-1:0] e_din = '0, e_rdat = '0;

    always @(negedge clk or negedge rst_n) begin : ref_model
        bit pop, rd_ok, gw, gr;
        if (!rst_n) begin
            exp_q.delete();
            last_was_rd = 1'b1;
            e_wr_rdy = 1'b0; e_rd_rdy = 1'b0; e_wen = 1'b0; e_rv = 1'b0;
            e_addr = '0; e_din = '0; e_rdat = '0;
        end else begin
            cyc++;
            e_rv = 1'b0;
            e_rdat = '0;
            if (exp_q.size() > 0) begin
                if (exp_q[0].t <= cyc) begin
                    e_rv = 1'b1;
                    e_rdat = exp_q[0].d;
                end
            end
            pop   = e_rv && rsp_ready;
            rd_ok = (exp_q.size() - int'(pop)) < RSP_DEPTH;
            gw = 1'b0;
            gr = 1'b0;
            if (wr_valid && rd_valid && rd_ok) begin
                if (last_was_rd) gw = 1'b1;
                else             gr = 1'b1;
            end else begin
                gw = wr_valid;
                gr = rd_valid && rd_ok;
            end
            e_wr_rdy = gw;
            e_rd_rdy = gr;
            e_wen    = gw;
            e_addr   = gw ? wr_addr : (gr ? rd_addr : '0);
            e_din    = gw ? wr_data : '0;
            if (pop) void'(exp_q.pop_front());
            if (gw) begin
                ref_mem[wr_addr] = wr_data;
                last_was_rd = 1'b0;
            end
            if (gr) begin
                exp_q.push_back('{d: ref_mem[rd_addr], t: cyc + 2});
                last_was_rd = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
        rd_valid = 1'b1; rd_addr = 3'd6;
        sample();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        checks++; if (ram_w_en !== 1'b0 || ram_addr !== 3'd0 || ram_data_in !== 8'h00) begin
            errors++; $display("FAIL reset_ram: got w_en=%b addr=%0d din=%0h want 0/0/0", ram_w_en, ram_addr, ram_data_in); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            errors++; $display("FAIL reset_rsp: got valid=%b data=%0h want 0/00", rsp_valid, rsp_data); end
        step();
        idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_prefill();
        for (int a = 0; a < DEPTH; a++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom);
            wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
            sample();
            checks++; if (wr_ready !== 1'b1 || ram_w_en !== 1'b1 || ram_addr !== AW'(a) || ram_data_in !== d) begin
                errors++; $display("FAIL prefill_write: got rdy=%b w_en=%b addr=%0d din=%0h want 1/1/%0d/%0h",
                                   wr_ready, ram_w_en, ram_addr, ram_data_in, a, d); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        sample();
        checks++; if (wr_ready !== 1'b1 || ram_w_en !== 1'b1 || ram_addr !== 3'd3 || ram_data_in !== 8'hA5) begin
            errors++; $display("FAIL wr_a5_drive: got rdy=%b w_en=%b addr=%0d din=%0h want 1/1/3/a5",
                               wr_ready, ram_w_en, ram_addr, ram_data_in); end
        step();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd3;
        sample();
        checks++; if (rd_ready !== 1'b1 || ram_w_en !== 1'b0 || ram_addr !== 3'd3) begin
            errors++; $display("FAIL rd_a5_drive: got rdy=%b w_en=%b addr=%0d want 1/0/3", rd_ready, ram_w_en, ram_addr); end
        step();
        rd_valid = 1'b0;
        sample();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_a5_early: got rsp_valid=%b want 0", rsp_valid); end
        step();
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
            errors++; $display("FAIL rd_a5_rsp: got valid=%b data=%0h want 1/a5", rsp_valid, rsp_data); end
        step();
        sample();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_a5_after: got rsp_valid=%b want 0", rsp_valid); end
        step();
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] d2;
        do_reset();
        rsp_ready = 1'b1;
        d2 = ref_mem[2];
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = WIDTH'($urandom);
        rd_valid = 1'b1; rd_addr = 3'd2;
        for (int i = 0; i < 6; i++) begin
            bit ew, ev;
            ew = (i % 2) == 0;
            ev = (i >= 3) && (i % 2 == 1);
            sample();
            checks++; if (wr_ready !== ew || rd_ready !== !ew || ram_w_en !== ew) begin
                errors++; $display("FAIL rr_grant[%0d]: got wr_rdy=%b rd_rdy=%b w_en=%b want %b/%b/%b",
                                   i, wr_ready, rd_ready, ram_w_en, ew, !ew, ew); end
            checks++; if (ram_addr !== (ew ? 3'd5 : 3'd2)) begin
                errors++; $display("FAIL rr_addr[%0d]: got %0d want %0d", i, ram_addr, ew ? 5 : 2); end
            checks++; if (rsp_valid !== ev || (ev && rsp_data !== d2)) begin
                errors++; $display("FAIL rr_rsp[%0d]: got valid=%b data=%0h want %b/%0h", i, rsp_valid, rsp_data, ev, d2); end
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d0, d1, d2;
        d0 = ref_mem[0]; d1 = ref_mem[1]; d2 = ref_mem[2];
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 3'd0;
        sample();
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_rd0: got rd_ready=%b want 1", rd_ready); end
        step();
        rd_addr = 3'd1;
        sample();
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_rd1: got rd_ready=%b want 1", rd_ready); end
        step();
        rd_addr = 3'd2;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: got rd_ready=%b want 0", k, rd_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== d0) begin
                errors++; $display("FAIL bp_head[%0d]: got valid=%b data=%0h want 1/%0h", k, rsp_valid, rsp_data, d0); end
            step();
        end
        rsp_ready = 1'b1;
        sample();
        checks++; if (rd_ready !== 1'b1 || rsp_data !== d0) begin
            errors++; $display("FAIL bp_release: got rd_ready=%b data=%0h want 1/%0h", rd_ready, rsp_data, d0); end
        step();
        rsp_ready = 1'b0; rd_valid = 1'b0;
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== d1) begin
            errors++; $display("FAIL bp_second: got valid=%b data=%0h want 1/%0h", rsp_valid, rsp_data, d1); end
        step();
        rsp_ready = 1'b1;
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== d1) begin
            errors++; $display("FAIL bp_second_pop: got valid=%b data=%0h want 1/%0h", rsp_valid, rsp_data, d1); end
        step();
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== d2) begin
            errors++; $display("FAIL bp_third: got valid=%b data=%0h want 1/%0h", rsp_valid, rsp_data, d2); end
        step();
        sample();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got rsp_valid=%b want 0", rsp_valid); end
        step();
    endtask

    task automatic test_raw();
        rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h3C;
        sample();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL raw_wr: got wr_ready=%b want 1", wr_ready); end
        step();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd7;
        sample();
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL raw_rd: got rd_ready=%b want 1", rd_ready); end
        step();
        rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h99;
        sample();
        checks++; if (wr_ready !== 1'b1 || ram_w_en !== 1'b1) begin
            errors++; $display("FAIL raw_wr2: got wr_ready=%b w_en=%b want 1/1", wr_ready, ram_w_en); end
        step();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd7;
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C) begin
            errors++; $display("FAIL raw_rsp: got valid=%b data=%0h want 1/3c", rsp_valid, rsp_data); end
        step();
        rd_valid = 1'b0;
        step();
        sample();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h99) begin
            errors++; $display("FAIL raw_new: got valid=%b data=%0h want 1/99", rsp_valid, rsp_data); end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 3'd0;
        sample();
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rmid_rd0: got rd_ready=%b want 1", rd_ready); end
        step();
        rd_addr = 3'd1;
        sample();
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rmid_rd1: got rd_ready=%b want 1", rd_ready); end
        step();
        rd_valid = 1'b0;
        sample();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: got rsp_valid=%b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            errors++; $display("FAIL rmid_async: got valid=%b data=%0h want 0/00", rsp_valid, rsp_data); end
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_quiet[%0d]: got rsp_valid=%b want 0", k, rsp_valid); end
            step();
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] exp_d [9];
        int got = 0;
        for (int i = 0; i < 9; i++) exp_d[i] = ref_mem[i % DEPTH];
        rsp_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bit ev;
            if (i < 9) begin
                rd_valid = 1'b1; rd_addr = AW'(i % DEPTH);
            end else begin
                rd_valid = 1'b0;
            end
            ev = (i >= 2) && (i <= 10);
            sample();
            if (i < 9) begin
                checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL stream_rdy[%0d]: got %b want 1", i, rd_ready); end
            end
            checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, rsp_valid, ev); end
            if (ev && rsp_valid === 1'b1) begin
                checks++; if (rsp_data !== exp_d[i-2]) begin
                    errors++; $display("FAIL stream_data[%0d]: got %0h want %0h", i - 2, rsp_data, exp_d[i-2]); end
                got++;
            end
            step();
        end
        checks++; if (got != 9) begin errors++; $display("FAIL stream_count: got %0d want 9", got); end
    endtask

    task automatic test_random();
        bit w_acc = 1'b1, r_acc = 1'b1;
        idle();
        for (int i = 0; i < 300; i++) begin
            if (!wr_valid || w_acc) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_addr  = AW'($urandom);
                wr_data  = WIDTH'($urandom);
            end
            if (!rd_valid || r_acc) begin
                rd_valid = ($urandom_range(0, 1) == 0);
                rd_addr  = AW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            sample();
            checks++; if (wr_ready !== e_wr_rdy || rd_ready !== e_rd_rdy) begin
                errors++; $display("FAIL rnd_ready[%0d]: got wr=%b rd=%b want %b/%b", i, wr_ready, rd_ready, e_wr_rdy, e_rd_rdy); end
            checks++; if (ram_w_en !== e_wen || ram_addr !== e_addr || (e_wen && ram_data_in !== e_din)) begin
                errors++; $display("FAIL rnd_ram[%0d]: got w_en=%b addr=%0d din=%0h want %b/%0d/%0h",
                                   i, ram_w_en, ram_addr, ram_data_in, e_wen, e_addr, e_din); end
            checks++; if (rsp_valid !== e_rv || (e_rv && rsp_data !== e_rdat)) begin
                errors++; $display("FAIL rnd_rsp[%0d]: got valid=%b data=%0h want %b/%0h", i, rsp_valid, rsp_data, e_rv, e_rdat); end
            w_acc = wr_valid && wr_ready;
            r_acc = rd_valid && rd_ready;
            step();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (4) step();
        sample();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got rsp_valid=%b want 0", rsp_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_raw();
        test_reset_mid();
        test_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule
